// File: rtl/imem_port_arbiter_if.sv
// Signal bundle for the shared instruction-memory port: IF fetch path, loader write stream, memory side.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic [31:0]       fetch_addr_i;
  logic [31:0]       fetch_instr_o;
  logic              fetch_stall_o;
  logic              ldr_valid_i;
  logic              ldr_ready_o;
  logic [31:0]       ldr_addr_i;
  logic [31:0]       ldr_data_i;
  logic [3:0]        ldr_be_i;
  logic              ldr_done_i;
  logic              core_hold_o;
  logic [15:0]       ldr_wr_cnt_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  // Arbiter side: owns the memory port and answers both requesters.
  modport master (
    input  fetch_addr_i, ldr_valid_i, ldr_addr_i, ldr_data_i, ldr_be_i, ldr_done_i, mem_rdata_i,
    output fetch_instr_o, fetch_stall_o, ldr_ready_o, core_hold_o, ldr_wr_cnt_o,
           mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

  modport slave (
    output fetch_addr_i, ldr_valid_i, ldr_addr_i, ldr_data_i, ldr_be_i, ldr_done_i, mem_rdata_i,
    input  fetch_instr_o, fetch_stall_o, ldr_ready_o, core_hold_o, ldr_wr_cnt_o,
           mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// IMEM port arbiter: combinational grant (0 cycles), loader waits 1 cycle from RUN, bursts capped at MAX_BURST.
// Backpressure: loader via ldr_ready_o, fetch via fetch_stall_o + NOP. IMEM_ARB_BOOT_EN adds the BOOT hold state.
module imem_port_arbiter #(
  parameter int          ADDR_W    = 12,
  parameter int          MAX_BURST = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk_i,
  input  logic                rst_i,
  imem_port_arbiter_if.master bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FSLOT = 2'd2
`ifdef IMEM_ARB_BOOT_EN
    , ST_BOOT = 2'd3
`endif
  } state_e;

`ifdef IMEM_ARB_BOOT_EN
  localparam state_e RST_STATE = ST_BOOT;
`else
  localparam state_e RST_STATE = ST_RUN;
`endif

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_e      state_q, state_d;
  logic [7:0]  burst_q, burst_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ldr_gnt;
  logic        core_hold;
  logic        ldr_hs;
  mem_req_t    req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    ldr_gnt   = 1'b0;
    core_hold = 1'b0;
    case (state_q)
`ifdef IMEM_ARB_BOOT_EN
      ST_BOOT: begin
        ldr_gnt   = 1'b1;
        core_hold = 1'b1;
        burst_d   = '0;
        if (bus.ldr_done_i) state_d = ST_RUN;
      end
`endif
      // Fetch is served while a fresh loader request waits one cycle.
      ST_RUN: begin
        burst_d = '0;
        if (bus.ldr_valid_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.ldr_valid_i) begin
          ldr_gnt = 1'b1;
          if (burst_q == BURST_LAST) begin
            state_d = ST_FSLOT;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 8'd1;
          end
        end else begin
          state_d = ST_RUN;
          burst_d = '0;
        end
      end
      ST_FSLOT: begin
        burst_d = '0;
        state_d = bus.ldr_valid_i ? ST_LOAD : ST_RUN;
      end
      default: begin
        state_d = RST_STATE;
        burst_d = '0;
      end
    endcase
  end

  // Async reset must kill an in-flight write in the same cycle, so the strobe is gated by rst_i.
  assign ldr_hs = ldr_gnt & bus.ldr_valid_i & ~rst_i;

  always_comb begin
    cnt_d = cnt_q;
    if (ldr_hs && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    req.addr  = bus.fetch_addr_i[ADDR_W+1:2];
    req.we    = 1'b0;
    req.be    = 4'b0000;
    req.wdata = bus.ldr_data_i;
    if (ldr_gnt) begin
      req.addr = bus.ldr_addr_i[ADDR_W+1:2];
      req.we   = ldr_hs;
      req.be   = bus.ldr_be_i;
    end
  end

  assign bus.mem_addr_o    = req.addr;
  assign bus.mem_we_o      = req.we;
  assign bus.mem_be_o      = req.be;
  assign bus.mem_wdata_o   = req.wdata;
  assign bus.ldr_ready_o   = ldr_gnt & ~rst_i;
  assign bus.fetch_stall_o = ldr_gnt;
  assign bus.fetch_instr_o = ldr_gnt ? NOP_INSTR : bus.mem_rdata_i;
  assign bus.core_hold_o   = core_hold;
  assign bus.ldr_wr_cnt_o  = cnt_q;

  logic unused_bits;
`ifdef IMEM_ARB_BOOT_EN
  assign unused_bits = ^{bus.fetch_addr_i[31:ADDR_W+2], bus.fetch_addr_i[1:0],
                         bus.ldr_addr_i[31:ADDR_W+2], bus.ldr_addr_i[1:0]};
`else
  assign unused_bits = ^{bus.fetch_addr_i[31:ADDR_W+2], bus.fetch_addr_i[1:0],
                         bus.ldr_addr_i[31:ADDR_W+2], bus.ldr_addr_i[1:0], bus.ldr_done_i};
`endif

  a_we_has_rdy: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.mem_we_o |-> bus.ldr_ready_o);
  a_stall_is_ldr: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.fetch_stall_o == bus.ldr_ready_o);
  a_burst_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(burst_q) < MAX_BURST);
  a_cnt_mono: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q >= $past(cnt_q));

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed table, hand sequences, randomized run against a history-based model.
module tb_imem_port_arbiter;
  localparam int          ADDR_W = 12;
  localparam int          MB     = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IMEM_ARB_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_sat = 1'b1;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(ADDR_W)) bi ();
  imem_port_arbiter_if #(.ADDR_W(ADDR_W)) si ();

  imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MB), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bi));
  imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(255), .NOP_INSTR(NOP)) dut_sat (
    .clk_i(clk), .rst_i(rst_sat), .bus(si));

  int n_cmp = 0;
  int n_bad = 0;
  bit sat_done = 1'b0;

  logic [31:0] mem     [0:4095];
  logic [31:0] exp_mem [0:4095];

  assign bi.mem_rdata_i = mem[bi.mem_addr_o];
  assign si.mem_rdata_i = 32'h0BAD_F00D;

  always @(posedge clk) begin
    if (bi.mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bi.mem_be_o[b]) mem[bi.mem_addr_o][8*b +: 8] <= bi.mem_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // Model state: booting, whether the loader asked last cycle / holds the port, current run of grants.
  bit m_boot;
  bit m_armed;
  int m_run;
  int m_cnt;

  task automatic model_reset();
    m_boot  = BOOT_EN;
    m_armed = 1'b0;
    m_run   = 0;
    m_cnt   = 0;
  endtask

  task automatic cyc(input logic v, input logic [31:0] la, input logic [31:0] ld, input logic [3:0] be,
                     input logic done, input logic [31:0] fa, input bit tab, input bit t_ldr);
    bit g;
    logic [31:0] exp_instr;
    bi.ldr_valid_i  = v;
    bi.ldr_addr_i   = la;
    bi.ldr_data_i   = ld;
    bi.ldr_be_i     = be;
    bi.ldr_done_i   = done;
    bi.fetch_addr_i = fa;
    @(negedge clk);
    g = m_boot || (v && m_armed && (m_run < MB));
    exp_instr = g ? NOP : exp_mem[fa[ADDR_W+1:2]];
    chk("ldr_ready", 32'(bi.ldr_ready_o), 32'(g));
    chk("mem_we", 32'(bi.mem_we_o), 32'(g && v));
    chk("fetch_stall", 32'(bi.fetch_stall_o), 32'(g));
    chk("fetch_instr", bi.fetch_instr_o, exp_instr);
    chk("core_hold", 32'(bi.core_hold_o), 32'(m_boot));
    chk("wr_cnt", 32'(bi.ldr_wr_cnt_o), 32'(m_cnt));
    chk("mem_addr", 32'(bi.mem_addr_o), g ? 32'(la[ADDR_W+1:2]) : 32'(fa[ADDR_W+1:2]));
    chk("mem_be", 32'(bi.mem_be_o), g ? 32'(be) : 32'd0);
    if (g) chk("mem_wdata", bi.mem_wdata_o, ld);
    if (tab) begin
      chk("tab_ready", 32'(bi.ldr_ready_o), 32'(t_ldr));
      chk("tab_stall", 32'(bi.fetch_stall_o), 32'(t_ldr));
    end
    @(posedge clk);
    if (g && v) begin
      if (m_cnt < 65535) m_cnt++;
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[la[ADDR_W+1:2]][8*b +: 8] = ld[8*b +: 8];
    end
    if (m_boot) begin
      if (done) begin
        m_boot  = 1'b0;
        m_armed = 1'b0;
        m_run   = 0;
      end
    end else if (g) begin
      m_run++;
      m_armed = 1'b1;
    end else begin
      m_run   = 0;
      m_armed = v;
    end
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] la;
    logic [31:0] ld;
    bit          ldr;
  } vec_t;

  vec_t  tab [28];
  string vs;
  string gs;
  int    rb_rows [8];
  logic  vr;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'h0;
      exp_mem[i] = 32'h0;
    end
    mem[0]     = 32'h1234_5678;
    exp_mem[0] = 32'h1234_5678;

    // Loader request pattern and expected owner (L = loader, F = fetch) per cycle from RUN.
    vs = {"0111101111111111111111111100"};
    gs = {"FFLLLFF", "LLLLLLLL", "F", "LLLLLLLL", "F", "L", "FF"};
    for (int i = 0; i < 28; i++) begin
      tab[i].v   = (vs[i] == "1");
      tab[i].la  = 32'h100 + 32'(4 * i);
      tab[i].ld  = 32'hC0DE_0000 + 32'(i);
      tab[i].ldr = (gs[i] == "L");
    end
    rb_rows = '{2, 4, 7, 14, 16, 25, 15, 6};

    bi.ldr_valid_i = 1'b0; bi.ldr_addr_i = '0; bi.ldr_data_i = '0; bi.ldr_be_i = '0;
    bi.ldr_done_i = 1'b0; bi.fetch_addr_i = '0;
    model_reset();

    @(negedge clk);
    chk("rst_cnt", 32'(bi.ldr_wr_cnt_o), 32'd0);
    chk("rst_we", 32'(bi.mem_we_o), 32'd0);
    chk("rst_hold", 32'(bi.core_hold_o), 32'(BOOT_EN));
    chk("rst_stall", 32'(bi.fetch_stall_o), 32'(BOOT_EN));
    chk("rst_instr", bi.fetch_instr_o, BOOT_EN ? NOP : 32'h1234_5678);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef IMEM_ARB_BOOT_EN
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'(4 * i), 32'hA000_0001 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    bi.fetch_addr_i = 32'h4; bi.ldr_valid_i = 1'b0; bi.ldr_done_i = 1'b0;
    #2;
    chk("boot_hold_off", 32'(bi.core_hold_o), 32'd0);
    chk("boot_readback", bi.fetch_instr_o, 32'hA000_0002);
    chk("boot_cnt", 32'(bi.ldr_wr_cnt_o), 32'd4);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h4, 1'b0, 1'b0);
`else
    bi.fetch_addr_i = 32'h0; bi.ldr_done_i = 1'b1;
    #2;
    chk("first_stall", 32'(bi.fetch_stall_o), 32'd0);
    chk("first_instr", bi.fetch_instr_o, 32'h1234_5678);
    chk("first_hold", 32'(bi.core_hold_o), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 28; i++)
      cyc(tab[i].v, tab[i].la, tab[i].ld, 4'hF, 1'b0, 32'h0, 1'b1, tab[i].ldr);

    for (int k = 0; k < 8; k++) begin
      bi.fetch_addr_i = tab[rb_rows[k]].la; bi.ldr_valid_i = 1'b0;
      #2;
      chk("readback", bi.fetch_instr_o, tab[rb_rows[k]].ldr ? tab[rb_rows[k]].ld : 32'h0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, tab[rb_rows[k]].la, 1'b0, 1'b0);
    end

    // Async reset lands in the cycle of the 5th burst write.
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 32'h180 + 32'(4 * k), 32'hBEEF_0000 + 32'(k), 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    bi.ldr_valid_i = 1'b1; bi.ldr_addr_i = 32'h200; bi.ldr_data_i = 32'hDEAD_BEEF; bi.ldr_be_i = 4'hF;
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", 32'(bi.mem_we_o), 32'd0);
    chk("midrst_cnt", 32'(bi.ldr_wr_cnt_o), 32'd0);
    chk("midrst_ready", 32'(bi.ldr_ready_o), 32'd0);
    chk("midrst_hold", 32'(bi.core_hold_o), 32'(BOOT_EN));
    @(posedge clk); #1;
    chk("midrst_no_write", mem[128], 32'h0);
    bi.ldr_valid_i = 1'b0;
    model_reset();
    rst = 1'b0;
    if (BOOT_EN) cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    vr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) vr = ~vr;
      cyc(vr, $urandom & 32'hFFFF_C03F, $urandom, 4'($urandom), 1'($urandom_range(0, 9) == 0),
          $urandom & 32'hFFFF_C03F, 1'b0, 1'b0);
    end
    bi.ldr_valid_i = 1'b0;

    for (int c = 0; c < 80000 && !sat_done; c++) @(posedge clk);
    if (!sat_done) begin
      n_cmp++; n_bad++;
      $display("FAIL sat_timeout: saturation run did not finish, required completion");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Second instance: stream writes until the counter saturates, then one unaligned partial write.
  initial begin
    int  tally;
    bit  found;
    tally = 0;
    found = 1'b0;
    si.ldr_valid_i = 1'b1; si.ldr_addr_i = 32'h0; si.ldr_data_i = 32'h5A5A_5A5A;
    si.ldr_be_i = 4'hF; si.ldr_done_i = 1'b0; si.fetch_addr_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_sat = 1'b0;
    for (int c = 0; c < 70000 && tally < 65535; c++) begin
      @(negedge clk);
      if (si.ldr_valid_i && si.ldr_ready_o) tally++;
    end
    if (tally < 65535) begin
      n_cmp++; n_bad++;
      $display("FAIL sat_tally: got %0d handshakes, required 65535", tally);
    end else begin
      @(posedge clk); #1;
      si.ldr_addr_i = 32'h7; si.ldr_be_i = 4'b0010; si.ldr_data_i = 32'h0000_AB00;
      @(negedge clk);
      chk("sat_cnt_full", 32'(si.ldr_wr_cnt_o), 32'h0000_FFFF);
      for (int c = 0; c < 300; c++) begin
        if (si.ldr_ready_o) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!found) begin
        n_cmp++; n_bad++;
        $display("FAIL sat_grant: no grant within 300 cycles, required a grant");
      end else begin
        chk("sat_mem_addr", 32'(si.mem_addr_o), 32'd1);
        chk("sat_mem_be", 32'(si.mem_be_o), 32'h2);
        chk("sat_mem_we", 32'(si.mem_we_o), 32'd1);
        @(posedge clk); #1;
        si.ldr_valid_i = 1'b0;
        @(negedge clk);
        chk("sat_cnt_hold", 32'(si.ldr_wr_cnt_o), 32'h0000_FFFF);
      end
    end
    sat_done = 1'b1;
  end

endmodule
